// File: rtl/sram_controller_if.sv
// Pipeline MEM-stage request/response fields plus the 16-bit SRAM pin bundle.
// slave = the controller; master = pipeline and SRAM model side.
interface sram_controller_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_DQ_in,
        output read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_DQ_in,
        input  read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store as two half-word beats on a 16-bit async SRAM; ready rises 3+WAIT_CYCLES cycles after the request is seen.
// ready is held low from request to completion so upstream stages freeze; one access in flight, inputs sampled only in IDLE.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOW  = 3'd1,
        HIGH = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [31:0] BASE32    = 32'(BASE_ADDR);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;

    logic        op_wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [3:0]  cnt;
    logic [17:0] addr_hold;
    logic [31:0] rdata;

    logic        req;
    logic [16:0] word_in;

    logic        ready_c;
    logic [17:0] addr_c;
    logic        we_n_c;
    logic        oe_c;
    logic [15:0] dq_out_c;

    assign req     = bus.MEM_R_EN | bus.MEM_W_EN;
    assign word_in = 17'((bus.ALU_Res - BASE32) >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        addr_c    = addr_hold;
        we_n_c    = 1'b1;
        oe_c      = 1'b0;
        dq_out_c  = 16'h0000;
        case (state)
            IDLE: begin
                ready_c = ~req;
                if (req) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                addr_c = {word, 1'b0};
                if (op_wr) begin
                    we_n_c   = 1'b0;
                    oe_c     = 1'b1;
                    dq_out_c = wdata[15:0];
                end
                state_nxt = HIGH;
            end
            HIGH: begin
                addr_c = {word, 1'b1};
                if (op_wr) begin
                    we_n_c   = 1'b0;
                    oe_c     = 1'b1;
                    dq_out_c = wdata[31:16];
                end
                state_nxt = (WAIT_CYCLES > 0) ? WAIT : DONE;
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latched request fields, read-back assembly and the WAIT counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr     <= 1'b0;
            word      <= '0;
            wdata     <= '0;
            cnt       <= '0;
            addr_hold <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr <= bus.MEM_W_EN;
                        word  <= word_in;
                        wdata <= bus.Val_Rm;
                    end
                end
                LOW: begin
                    if (!op_wr) begin
                        rdata[15:0] <= bus.SRAM_DQ_in;
                    end
                end
                HIGH: begin
                    if (!op_wr) begin
                        rdata[31:16] <= bus.SRAM_DQ_in;
                    end
                    addr_hold <= {word, 1'b1};
                    cnt       <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ready is forced high while reset is asserted, whatever the request lines do.
    assign bus.ready       = rst ? ready_c : 1'b1;
    assign bus.read_data   = rdata;
    assign bus.SRAM_ADDR   = addr_c;
    assign bus.SRAM_WE_N   = we_n_c;
    assign bus.SRAM_DQ_oe  = oe_c;
    assign bus.SRAM_DQ_out = dq_out_c;

endmodule
